// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding, default address width,
// instruction opcodes used by the decoder, and the jump condition rule.
package cpu_pkg;

  localparam int ADDR_W_DEFAULT = 10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

  // Opcode field (IR[15:12]) values shared with the combinational decoder.
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_HALT  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_PUSH  = 4'h4;
  localparam logic [3:0] OP_POP   = 4'h5;
  localparam logic [3:0] OP_COPY  = 4'h6;
  localparam logic [3:0] OP_LDC   = 4'h7;
  localparam logic [3:0] OP_ADD   = 4'h8;
  localparam logic [3:0] OP_SUB   = 4'h9;
  localparam logic [3:0] OP_AND   = 4'hA;
  localparam logic [3:0] OP_OR    = 4'hB;
  localparam logic [3:0] OP_SHL   = 4'hC;
  localparam logic [3:0] OP_SHR   = 4'hD;
  localparam logic [3:0] OP_CMP   = 4'hE;
  localparam logic [3:0] OP_JMP   = 4'hF;

  // neg/zero both clear means an unconditional jump.
  function automatic logic jump_taken(input logic neg, input logic zero,
                                      input logic flag_n, input logic flag_z);
    return (!neg && !zero) || (neg && flag_n) || (zero && flag_z);
  endfunction

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer register with push/pop update, pop address (sp+1) and a sticky
// wrap indicator; updates only on the committed memory edge.
module stack_ptr
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] STACK_TOP = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] pop_addr,
  output logic              stack_err
);

  assign pop_addr = sp + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= STACK_TOP;
      stack_err <= 1'b0;
    end else if (push) begin
      sp <= sp - ADDR_W'(1);
      if (sp == '0) stack_err <= 1'b1;
    end else if (pop) begin
      sp <= pop_addr;
      if (sp == '1) stack_err <= 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory sequencer owning PC, SP and flags.
// Arbitrates the single memory port between instruction fetch and data access.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] STACK_TOP = '1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              halt,
  input  logic              jump,
  input  logic              neg,
  input  logic              zero,
  input  logic              compare,
  input  logic              stack,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              alu_enable,
  input  logic              reg_load,
  input  logic              constant,
  input  logic [ADDR_W-1:0] d_out,
  input  logic [ADDR_W-1:0] reg_val,
  input  logic              alu_neg,
  input  logic              alu_zero,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              ir_load,
  output logic              reg_we,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] sp,
  output logic              flag_n,
  output logic              flag_z,
  output logic              halted,
  output logic              stack_err,
  output logic [2:0]        state
);

  seq_state_t        cur, nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] sp_pop_addr;
  logic              flag_ld;
  logic              is_push, is_pop;
  logic              push_commit, pop_commit;
  logic              ir_load_raw, reg_we_raw;

  assign is_push = stack & mem_write;
  assign is_pop  = stack & mem_read;

  stack_ptr #(
    .ADDR_W    (ADDR_W),
    .STACK_TOP (STACK_TOP)
  ) u_stack_ptr (
    .clk       (clk),
    .reset     (reset),
    .push      (push_commit),
    .pop       (pop_commit),
    .sp        (sp),
    .pop_addr  (sp_pop_addr),
    .stack_err (stack_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      cur    <= S_IDLE;
      pc     <= RESET_PC;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      cur <= nxt;
      pc  <= pc_nxt;
      if (flag_ld) begin
        flag_n <= alu_neg;
        flag_z <= alu_zero;
      end
    end
  end

  always_comb begin
    nxt         = cur;
    pc_nxt      = pc;
    flag_ld     = 1'b0;
    push_commit = 1'b0;
    pop_commit  = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = pc;
    ir_load_raw = 1'b0;
    reg_we_raw  = 1'b0;
    unique case (cur)
      S_IDLE: if (run) nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load_raw = 1'b1;
          pc_nxt      = pc + ADDR_W'(1);
          nxt         = S_DECODE;
        end
      end
      S_DECODE: nxt = S_EXEC;
      S_EXEC: begin
        if (halt) begin
          nxt = S_HALT;
        end else begin
          flag_ld    = compare & alu_enable;
          // Loads write the register file from MEM, not here.
          reg_we_raw = alu_enable | (reg_load & ~mem_read);
          if (jump && jump_taken(neg, zero, flag_n, flag_z))
            pc_nxt = constant ? d_out : reg_val;
          nxt = (mem_read | mem_write) ? S_MEM : S_FETCH;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = mem_write;
        if (is_push)     mem_addr = sp;
        else if (is_pop) mem_addr = sp_pop_addr;
        else             mem_addr = reg_val;
        if (mem_ack) begin
          reg_we_raw  = mem_read;
          push_commit = is_push;
          pop_commit  = is_pop;
          nxt         = S_FETCH;
        end
      end
      S_HALT: if (run) nxt = S_FETCH;
      default: nxt = S_IDLE;
    endcase
  end

  // A reset on the ack edge abandons the access, so the ack-qualified strobes are masked.
  assign ir_load = ir_load_raw & ~reset;
  assign reg_we  = reg_we_raw & ~reset;
  assign halted  = (cur == S_HALT);
  assign state   = cur;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed scenarios plus a randomized instruction stream checked against an
// instruction-level model of PC, SP, flags and memory port behaviour.
module tb_cpu_sequencer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset, run, halt, jump, neg, zero, compare, stack;
  logic          mem_read, mem_write, alu_enable, reg_load, constant;
  logic [AW-1:0] d_out, reg_val;
  logic          alu_neg, alu_zero, mem_ack;
  logic          mem_req, mem_we, ir_load, reg_we, flag_n, flag_z, halted, stack_err;
  logic [AW-1:0] mem_addr, pc, sp;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] m_pc, m_sp;
  logic          m_n, m_z, m_err;

  cpu_sequencer #(.ADDR_W(AW), .RESET_PC(10'd0), .STACK_TOP(10'h3FF)) dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .jump(jump), .neg(neg),
    .zero(zero), .compare(compare), .stack(stack), .mem_read(mem_read),
    .mem_write(mem_write), .alu_enable(alu_enable), .reg_load(reg_load),
    .constant(constant), .d_out(d_out), .reg_val(reg_val), .alu_neg(alu_neg),
    .alu_zero(alu_zero), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .ir_load(ir_load), .reg_we(reg_we), .pc(pc), .sp(sp),
    .flag_n(flag_n), .flag_z(flag_z), .halted(halted), .stack_err(stack_err),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic clear_ctrl();
    halt = 0; jump = 0; neg = 0; zero = 0; compare = 0; stack = 0;
    mem_read = 0; mem_write = 0; alu_enable = 0; reg_load = 0; constant = 0;
    d_out = '0; reg_val = '0; alu_neg = 0; alu_zero = 0;
  endtask

  task automatic do_reset();
    reset = 1; run = 0; mem_ack = 0; clear_ctrl();
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  task automatic start_run();
    run = 1; @(negedge clk); run = 0;
  endtask

  task automatic nop_instr();
    mem_ack = 1; @(negedge clk); mem_ack = 0; clear_ctrl();
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; run = 0; mem_ack = 0; clear_ctrl();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 3'd0 || pc !== 10'd0 || sp !== 10'h3FF) begin
      errors++; $display("FAIL reset_regs: state=%0d pc=%h sp=%h expected 0 000 3ff", state, pc, sp);
    end
    checks++;
    if ({flag_n, flag_z, stack_err, halted} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: n,z,err,halted=%b expected 0000", {flag_n, flag_z, stack_err, halted});
    end
    checks++;
    if ({mem_req, mem_we, ir_load, reg_we} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes: req,we,ir,reg=%b expected 0000", {mem_req, mem_we, ir_load, reg_we});
    end
    reset = 0;
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL idle_hold: state=%0d mem_req=%b expected 0 0", state, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_first_fetch();
    run = 1; @(negedge clk); run = 0;
    mem_ack = 1; #1;
    checks++;
    if (state !== 3'd1 || mem_req !== 1'b1 || mem_addr !== 10'd0 || ir_load !== 1'b1) begin
      errors++; $display("FAIL first_fetch: state=%0d req=%b addr=%h ir=%b expected 1 1 000 1", state, mem_req, mem_addr, ir_load);
    end
    @(negedge clk); mem_ack = 0; #1;
    checks++;
    if (state !== 3'd2 || pc !== 10'd1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL first_decode: state=%0d pc=%h req=%b expected 2 001 0", state, pc, mem_req);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL first_exec: state=%0d expected 3", state);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd1 || mem_addr !== 10'd1) begin
      errors++; $display("FAIL second_fetch: state=%0d addr=%h expected 1 001", state, mem_addr);
    end
  endtask

  task automatic test_wait_states();
    for (int w = 0; w < 4; w++) begin
      mem_ack = (w == 3); #1;
      checks++;
      if (state !== 3'd1 || mem_req !== 1'b1 || mem_addr !== 10'd1 || ir_load !== (w == 3)) begin
        errors++; $display("FAIL fetch_wait w=%0d: state=%0d req=%b addr=%h ir=%b expected 1 1 001 %b",
                           w, state, mem_req, mem_addr, ir_load, (w == 3));
      end
      @(negedge clk);
    end
    mem_ack = 0; #1;
    checks++;
    if (state !== 3'd2 || mem_req !== 1'b0 || pc !== 10'd2) begin
      errors++; $display("FAIL fetch_wait_after: state=%0d req=%b pc=%h expected 2 0 002", state, mem_req, pc);
    end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_jumps();
    mem_ack = 1; @(negedge clk); mem_ack = 0;
    clear_ctrl(); alu_enable = 1; compare = 1; alu_neg = 1; alu_zero = 0;
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd3 || reg_we !== 1'b1) begin
      errors++; $display("FAIL cmp_exec: state=%0d reg_we=%b expected 3 1", state, reg_we);
    end
    @(negedge clk); #1;
    checks++;
    if (flag_n !== 1'b1 || flag_z !== 1'b0 || pc !== 10'd3) begin
      errors++; $display("FAIL cmp_flags: n=%b z=%b pc=%h expected 1 0 003", flag_n, flag_z, pc);
    end
    mem_ack = 1; @(negedge clk); mem_ack = 0;
    clear_ctrl(); jump = 1; neg = 1; constant = 1; d_out = 10'h123; reg_val = 10'h2AA;
    @(negedge clk); #1;
    checks++;
    if (reg_we !== 1'b0) begin
      errors++; $display("FAIL jmpl_exec: reg_we=%b expected 0", reg_we);
    end
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd1 || mem_addr !== 10'h123 || flag_n !== 1'b1) begin
      errors++; $display("FAIL jmpl_taken: state=%0d addr=%h n=%b expected 1 123 1", state, mem_addr, flag_n);
    end
    mem_ack = 1; @(negedge clk); mem_ack = 0;
    clear_ctrl(); jump = 1; zero = 1; constant = 1; d_out = 10'h055;
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (state !== 3'd1 || mem_addr !== 10'h124) begin
      errors++; $display("FAIL jmpe_not_taken: state=%0d addr=%h expected 1 124", state, mem_addr);
    end
    clear_ctrl();
  endtask

  task automatic test_stack();
    do_reset(); start_run();
    mem_ack = 1; @(negedge clk); mem_ack = 0;
    clear_ctrl(); stack = 1; mem_write = 1;
    @(negedge clk); @(negedge clk);
    mem_ack = 1; #1;
    checks++;
    if (state !== 3'd4 || mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h3FF || reg_we !== 1'b0) begin
      errors++; $display("FAIL push_mem: state=%0d req=%b we=%b addr=%h reg_we=%b expected 4 1 1 3ff 0",
                         state, mem_req, mem_we, mem_addr, reg_we);
    end
    @(negedge clk); mem_ack = 0; #1;
    checks++;
    if (state !== 3'd1 || sp !== 10'h3FE || mem_addr !== 10'd1) begin
      errors++; $display("FAIL push_sp: state=%0d sp=%h addr=%h expected 1 3fe 001", state, sp, mem_addr);
    end
    mem_ack = 1; @(negedge clk); mem_ack = 0;
    clear_ctrl(); stack = 1; mem_read = 1; reg_load = 1;
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd3 || reg_we !== 1'b0) begin
      errors++; $display("FAIL pop_exec: state=%0d reg_we=%b expected 3 0", state, reg_we);
    end
    @(negedge clk); mem_ack = 1; #1;
    checks++;
    if (state !== 3'd4 || mem_we !== 1'b0 || mem_addr !== 10'h3FF || reg_we !== 1'b1) begin
      errors++; $display("FAIL pop_mem: state=%0d we=%b addr=%h reg_we=%b expected 4 0 3ff 1",
                         state, mem_we, mem_addr, reg_we);
    end
    @(negedge clk); mem_ack = 0; #1;
    checks++;
    if (sp !== 10'h3FF || stack_err !== 1'b0) begin
      errors++; $display("FAIL pop_sp: sp=%h err=%b expected 3ff 0", sp, stack_err);
    end
    mem_ack = 1; @(negedge clk); mem_ack = 0;
    @(negedge clk); @(negedge clk);
    mem_ack = 1; #1;
    checks++;
    if (mem_addr !== 10'h000 || reg_we !== 1'b1) begin
      errors++; $display("FAIL pop_wrap_addr: addr=%h reg_we=%b expected 000 1", mem_addr, reg_we);
    end
    @(negedge clk); mem_ack = 0; #1;
    checks++;
    if (sp !== 10'h000 || stack_err !== 1'b1) begin
      errors++; $display("FAIL pop_wrap_sp: sp=%h err=%b expected 000 1", sp, stack_err);
    end
    clear_ctrl();
  endtask

  task automatic test_halt();
    do_reset(); start_run();
    repeat (5) nop_instr();
    mem_ack = 1; #1;
    checks++;
    if (state !== 3'd1 || mem_addr !== 10'd5) begin
      errors++; $display("FAIL halt_fetch: state=%0d addr=%h expected 1 005", state, mem_addr);
    end
    @(negedge clk); mem_ack = 0; clear_ctrl(); halt = 1;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      mem_ack = rbit(); #1;
      checks++;
      if (halted !== 1'b1 || mem_req !== 1'b0 || state !== 3'd5) begin
        errors++; $display("FAIL halt_hold i=%0d: halted=%b req=%b state=%0d expected 1 0 5", i, halted, mem_req, state);
      end
      @(negedge clk);
    end
    mem_ack = 0; halt = 0; run = 1;
    @(negedge clk); run = 0; #1;
    checks++;
    if (state !== 3'd1 || mem_addr !== 10'd6 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_resume: state=%0d addr=%h halted=%b expected 1 006 0", state, mem_addr, halted);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); start_run();
    mem_ack = 1; @(negedge clk); mem_ack = 0;
    clear_ctrl(); stack = 1; mem_read = 1; reg_load = 1;
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (state !== 3'd4 || mem_req !== 1'b1 || mem_addr !== 10'h000 || reg_we !== 1'b0) begin
        errors++; $display("FAIL mid_wait i=%0d: state=%0d req=%b addr=%h reg_we=%b expected 4 1 000 0",
                           i, state, mem_req, mem_addr, reg_we);
      end
      @(negedge clk);
    end
    reset = 1; mem_ack = 1; #1;
    checks++;
    if (reg_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset_we: reg_we=%b expected 0", reg_we);
    end
    @(negedge clk); mem_ack = 0; #1;
    checks++;
    if (mem_req !== 1'b0 || state !== 3'd0 || sp !== 10'h3FF || stack_err !== 1'b0 || reg_we !== 1'b0) begin
      errors++; $display("FAIL mid_reset_after: req=%b state=%0d sp=%h err=%b reg_we=%b expected 0 0 3ff 0 0",
                         mem_req, state, sp, stack_err, reg_we);
    end
    reset = 0; clear_ctrl();
    @(negedge clk); #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: state=%0d req=%b expected 0 0", state, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int            fw, mw, kind;
    logic          exp_we, taken;
    logic [AW-1:0] exp_addr;
    do_reset();
    m_pc = '0; m_sp = 10'h3FF; m_n = 0; m_z = 0; m_err = 0;
    start_run();
    for (int n = 0; n < 200; n++) begin
      fw = $urandom_range(0, 2); mw = $urandom_range(0, 2); kind = $urandom_range(0, 6);
      run = rbit();
      for (int w = 0; w <= fw; w++) begin
        mem_ack = (w == fw); #1;
        checks++;
        if (state !== 3'd1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== m_pc || ir_load !== (w == fw)) begin
          errors++; $display("FAIL rnd_fetch n=%0d: state=%0d req=%b we=%b addr=%h ir=%b expected 1 1 0 %h %b",
                             n, state, mem_req, mem_we, mem_addr, ir_load, m_pc, (w == fw));
        end
        @(negedge clk);
      end
      m_pc = m_pc + 1'b1;
      clear_ctrl();
      alu_neg = rbit(); alu_zero = rbit(); reg_val = AW'($urandom); d_out = AW'($urandom);
      case (kind)
        0: begin alu_enable = 1; compare = rbit(); end
        1: reg_load = 1;
        2: begin jump = 1; neg = rbit(); zero = rbit(); constant = rbit(); end
        3: begin mem_read = 1; reg_load = 1; end
        4: mem_write = 1;
        5: begin stack = 1; mem_write = 1; end
        default: begin stack = 1; mem_read = 1; reg_load = 1; end
      endcase
      mem_ack = rbit(); #1;
      checks++;
      if (state !== 3'd2 || pc !== m_pc || mem_req !== 1'b0 || ir_load !== 1'b0 || reg_we !== 1'b0) begin
        errors++; $display("FAIL rnd_decode n=%0d: state=%0d pc=%h req=%b ir=%b reg_we=%b expected 2 %h 0 0 0",
                           n, state, pc, mem_req, ir_load, reg_we, m_pc);
      end
      @(negedge clk);
      mem_ack = rbit();
      exp_we = (kind == 0) || (kind == 1);
      #1;
      checks++;
      if (state !== 3'd3 || reg_we !== exp_we || mem_req !== 1'b0 || ir_load !== 1'b0) begin
        errors++; $display("FAIL rnd_exec n=%0d kind=%0d: state=%0d reg_we=%b req=%b ir=%b expected 3 %b 0 0",
                           n, kind, state, reg_we, mem_req, ir_load, exp_we);
      end
      if (kind == 2) begin
        taken = (!neg && !zero) || (neg && m_n) || (zero && m_z);
        if (taken) m_pc = constant ? d_out : reg_val;
      end
      if (kind == 0 && compare) begin m_n = alu_neg; m_z = alu_zero; end
      @(negedge clk);
      if (kind >= 3) begin
        if (kind == 5)      exp_addr = m_sp;
        else if (kind == 6) exp_addr = m_sp + 1'b1;
        else                exp_addr = reg_val;
        for (int w = 0; w <= mw; w++) begin
          mem_ack = (w == mw); #1;
          checks++;
          if (state !== 3'd4 || mem_req !== 1'b1 || mem_we !== mem_write || mem_addr !== exp_addr ||
              reg_we !== ((w == mw) && mem_read)) begin
            errors++; $display("FAIL rnd_mem n=%0d kind=%0d: state=%0d req=%b we=%b addr=%h reg_we=%b expected 4 1 %b %h %b",
                               n, kind, state, mem_req, mem_we, mem_addr, reg_we, mem_write, exp_addr, ((w == mw) && mem_read));
          end
          @(negedge clk);
        end
        if (kind == 5) begin
          if (m_sp == 10'h000) m_err = 1;
          m_sp = m_sp - 1'b1;
        end else if (kind == 6) begin
          if (m_sp == 10'h3FF) m_err = 1;
          m_sp = m_sp + 1'b1;
        end
      end
      mem_ack = 0; #1;
      checks++;
      if (state !== 3'd1 || pc !== m_pc || sp !== m_sp || flag_n !== m_n || flag_z !== m_z || stack_err !== m_err) begin
        errors++; $display("FAIL rnd_arch n=%0d: state=%0d pc=%h sp=%h n=%b z=%b err=%b expected 1 %h %h %b %b %b",
                           n, state, pc, sp, flag_n, flag_z, stack_err, m_pc, m_sp, m_n, m_z, m_err);
      end
    end
    run = 0; mem_ack = 0; clear_ctrl();
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_wait_states();
    test_jumps();
    test_stack();
    test_halt();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 16-bit CPU. It walks each instruction through fetch, decode, execute and memory phases, and owns the program counter, stack pointer and condition flags. It arbitrates the single memory port between instruction fetch and data load/store/push/pop, and turns the combinational decoder's control bits into timed enables for the register file, ALU flags and memory.

## Interface
Parameters:
- ADDR_W, 10: width of the memory address, PC and SP.
- RESET_PC, 0: PC value after reset.
- STACK_TOP, 2**ADDR_W-1: SP value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  start/resume pulse, honoured only in IDLE and HALT.
- halt, jump, neg, zero, compare, stack, mem_read, mem_write, alu_enable, reg_load, constant  in  1 each  decoded control bits for the current IR.
- d_out  in  ADDR_W  decoded constant, used as the jump target when `constant`=1.
- reg_val  in  ADDR_W  regX operand value: the jump target when `constant`=0, and the load/store address.
- alu_neg, alu_zero  in  1  ALU result flags.
- mem_ack  in  1  memory completes the request on this edge.
- mem_req  out  1  memory request.
- mem_we  out  1  write strobe, qualified by mem_req.
- mem_addr  out  ADDR_W  request address.
- ir_load  out  1  latch fetched word into IR.
- reg_we  out  1  register file write enable.
- pc  out  ADDR_W  program counter.
- sp  out  ADDR_W  stack pointer.
- flag_n, flag_z  out  1  latched condition flags.
- halted  out  1  high in HALT.
- stack_err  out  1  sticky SP wrap indicator.
- state  out  3  current FSM state, for debug.

## Operation
States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.

- **Reset** (sync): state=IDLE, pc=RESET_PC, sp=STACK_TOP, flag_n=flag_z=0, stack_err=0. All strobes (mem_req, mem_we, ir_load, reg_we) are 0 and halted=0.
- **IDLE:** on run=1 go to FETCH.
- **FETCH:** mem_req=1, mem_we=0, mem_addr=pc. Hold until mem_ack. On the ack edge: ir_load=1, pc<=pc+1 (wrapping 2**ADDR_W-1 to 0), go to DECODE.
- **DECODE:** one cycle; no strobes. Control inputs settle from the new IR. Then go to EXEC.
- **EXEC:**
  - If halt: go to HALT.
  - If compare & alu_enable: flag_n<=alu_neg, flag_z<=alu_zero.
  - If alu_enable | shift_op | copy (reg_load & !mem_read): reg_we=1.
  - If jump: taken = (!neg & !zero) | (neg & flag_n) | (zero & flag_z). When taken, pc <= constant ? d_out : reg_val. Flags are not modified by jumps.
  - If mem_read | mem_write: go to MEM. Otherwise go to FETCH.
- **MEM:** mem_req=1, mem_we=mem_write.
  - Address: stack push (stack & mem_write) uses sp; stack pop (stack & mem_read) uses sp+1; non-stack uses reg_val.
  - On the ack edge: reg_we=1 if mem_read. Push: sp<=sp-1. Pop: sp<=sp+1. Then go to FETCH.
- **SP wrap:** a push at sp=0 or a pop at sp=2**ADDR_W-1 wraps modulo 2**ADDR_W and sets stack_err. The operation still completes.
- **HALT:** halted=1, no requests. On run=1 go to FETCH; execution resumes at the current pc, which is the instruction after the halt.

## Timing
- Outputs are Moore-decoded from state and registers. The exceptions are ir_load and MEM-state reg_we, which are state & mem_ack.
- mem_ack may be high in the first request cycle (zero-wait memory).
- mem_req, mem_we and mem_addr stay stable until the ack edge. mem_req drops in the cycle after the ack.
- Zero-wait latency: ALU/jump instructions take 3 cycles (FETCH, DECODE, EXEC). Memory/stack instructions take 4 cycles. Each memory wait cycle adds 1 to its phase.
- A taken jump's pc is visible the cycle after EXEC, which is the first FETCH address.
- reset overrides all other inputs, including mid-MEM and mid-FETCH: the request is abandoned, mem_req=0 from the next cycle, and no SP or register update occurs.
- run held high continuously is harmless: it is only sampled in IDLE and HALT.
- mem_ack outside FETCH and MEM is ignored.

## Structure
- The shared package `cpu_pkg` holds:
  - the state encoding constants (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5);
  - the ADDR_W default;
  - the opcode constants shared with the decoder.
- One sub-module is natural: `stack_ptr`. It holds the SP register, the inc/dec logic, the pop-address (sp+1) output and the stack_err sticky bit.

## Test plan
- **Reset and first fetch:** reset 2 cycles, run pulse, memory acks immediately → mem_addr=0 in FETCH, pc=1 after the ack, state sequence 1,2,3,1.
- **Wait states:** ack delayed 3 cycles in FETCH → mem_req held 4 cycles with mem_addr constant; ir_load is high only on the ack cycle.
- **Conditional jumps:**
  - compare with alu_neg=1, alu_zero=0 → flag_n=1.
  - jmpl with constant, d_out=0x123 → next FETCH addr 0x123.
  - jmpe from the same state → not taken, pc increments.
- **Stack sequence:** push then pop from reset → push writes at 0x3FF and sp becomes 0x3FE; pop reads 0x3FF, reg_we pulses, sp returns to 0x3FF. A pop at sp=0x3FF wraps sp to 0x000 and sets stack_err.
- **Halt and resume:** halt at address 5 → halted=1 and no mem_req for 10 cycles; run → FETCH at 6.
- **Reset mid-operation:** reset asserted during a pending MEM request → mem_req=0 the next cycle, sp=STACK_TOP, state=IDLE, reg_we never pulses.
